// File: rtl/rv32im_alu_if.sv
// Operand/opcode bundle into the RV32IM ALU and its registered result back out.
// Signal names match the legacy flat ports so existing hookups map one-to-one.
interface rv32im_alu_if;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic [4:0]  OPCODE;
   logic [31:0] ALU_OUTPUT;

   modport master (
      output DATA1,
      output DATA2,
      output OPCODE,
      input  ALU_OUTPUT
   );

   modport slave (
      input  DATA1,
      input  DATA2,
      input  OPCODE,
      output ALU_OUTPUT
   );
endinterface

// File: rtl/rv32im_alu.sv
// Registered RV32I/RV32M integer ALU: one-cycle latency for every opcode,
// with RISC-V divide-by-zero and signed-overflow results and no traps.
module rv32im_alu (
   input  logic        CLK,
   input  logic        RESET_N,
   rv32im_alu_if.slave bus
);

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLL    = 5'd2,
      OP_SLT    = 5'd3,
      OP_SLTU   = 5'd4,
      OP_XOR    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_OR     = 5'd8,
      OP_AND    = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } op_e;

   op_e         op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;

   logic        mul_a_signed;
   logic        mul_b_signed;
   logic [63:0] mul_a_ext;
   logic [63:0] mul_b_ext;
   logic [63:0] product;

   logic        div_signed;
   logic        neg_a;
   logic        neg_b;
   logic        div_by_zero;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_div;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_res;
   logic [31:0] r_res;

   logic [31:0] alu_output_d;
   logic [31:0] alu_output_q;

   always_comb begin
      op    = op_e'(bus.OPCODE);
      a     = bus.DATA1;
      b     = bus.DATA2;
      shamt = b[4:0];

      // One 64x64 multiplier serves all four multiply ops; the operand
      // extension picks signed or unsigned interpretation per opcode.
      mul_a_signed = (op == OP_MULH) || (op == OP_MULHSU);
      mul_b_signed = (op == OP_MULH);
      mul_a_ext    = {{32{mul_a_signed & a[31]}}, a};
      mul_b_ext    = {{32{mul_b_signed & b[31]}}, b};
      product      = mul_a_ext * mul_b_ext;

      // Signed divide runs on magnitudes through the shared unsigned divider;
      // 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
      div_signed  = (op == OP_DIV) || (op == OP_REM);
      neg_a       = div_signed & a[31];
      neg_b       = div_signed & b[31];
      div_by_zero = (b == '0);
      a_mag       = neg_a ? (~a + 32'd1) : a;
      b_mag       = neg_b ? (~b + 32'd1) : b;
      b_div       = div_by_zero ? 32'd1 : b_mag;
      q_mag       = a_mag / b_div;
      r_mag       = a_mag % b_div;
      q_res       = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
      r_res       = neg_a ? (~r_mag + 32'd1) : r_mag;

      alu_output_d = '0;
      case (op)
         OP_ADD:    alu_output_d = a + b;
         OP_SUB:    alu_output_d = a - b;
         OP_SLL:    alu_output_d = a << shamt;
         OP_SLT:    alu_output_d = {31'b0, ($signed(a) < $signed(b))};
         OP_SLTU:   alu_output_d = {31'b0, (a < b)};
         OP_XOR:    alu_output_d = a ^ b;
         OP_SRL:    alu_output_d = a >> shamt;
         OP_SRA:    alu_output_d = $signed(a) >>> shamt;
         OP_OR:     alu_output_d = a | b;
         OP_AND:    alu_output_d = a & b;
         OP_MUL:    alu_output_d = product[31:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  alu_output_d = product[63:32];
         OP_DIV,
         OP_DIVU:   alu_output_d = div_by_zero ? '1 : q_res;
         OP_REM,
         OP_REMU:   alu_output_d = div_by_zero ? a : r_res;
         default:   alu_output_d = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         alu_output_q <= '0;
      end else begin
         alu_output_q <= alu_output_d;
      end
   end

   assign bus.ALU_OUTPUT = alu_output_q;

endmodule

// File: tb/tb_rv32im_alu.sv
// Scoreboard bench for rv32im_alu: directed corner vectors, reset checks and a
// randomized pass checked against a 64-bit reference model.
module tb_rv32im_alu;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_entry_t;

   logic clk;
   logic rst_n;
   int unsigned n_vec;
   int unsigned n_err;
   sb_entry_t   sb_q[$];

   rv32im_alu_if bus ();

   rv32im_alu dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op);
      longint          sa;
      longint          sb;
      longint          sp;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned up;
      logic [31:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      r  = 32'd0;
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a - b;
         5'd2:  r = a << b[4:0];
         5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
         5'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
         5'd5:  r = a ^ b;
         5'd6:  r = a >> b[4:0];
         5'd7:  begin sp = sa >>> b[4:0]; r = sp[31:0]; end
         5'd8:  r = a | b;
         5'd9:  r = a & b;
         5'd10: begin up = ua * ub; r = up[31:0]; end
         5'd11: begin sp = sa * sb; r = sp[63:32]; end
         5'd12: begin sp = sa * longint'(ub); r = sp[63:32]; end
         5'd13: begin up = ua * ub; r = up[63:32]; end
         5'd14: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else begin sp = sa / sb; r = sp[31:0]; end
         end
         5'd15: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         5'd16: begin
            if (b == 32'd0) r = a;
            else begin sp = sa % sb; r = sp[31:0]; end
         end
         5'd17: r = (b == 32'd0) ? a : a % b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic drive_push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                             input string tag, input logic [31:0] exp);
      sb_entry_t e;
      bus.DATA1  = a;
      bus.DATA2  = b;
      bus.OPCODE = op;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                        input string tag, input logic [31:0] exp);
      @(negedge clk);
      drive_push(a, b, op, tag, exp);
   endtask

   // Each entry pushed at a falling edge is captured on the next rising edge.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, bus.ALU_OUTPUT, e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [31:0] sweep_exp [18];
      logic [31:0] ra;
      logic [31:0] rb;
      logic [4:0]  rop;

      sweep_exp = '{32'd9, 32'd3, 32'd48, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd7, 32'd2,
                    32'd18, 32'd0, 32'd0, 32'd0, 32'd2, 32'd2, 32'd0, 32'd0};
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.DATA1  = 32'd0;
      bus.DATA2  = 32'd0;
      bus.OPCODE = 5'd0;

      #3;
      check_eq("reset_state", bus.ALU_OUTPUT, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         issue(32'd6, 32'd3, 5'(i), $sformatf("sweep_op%0d", i), sweep_exp[i]);
      end

      issue(32'hFFFF_FFFF, 32'd2, 5'd3,  "neg_slt",    32'd1);
      issue(32'hFFFF_FFFF, 32'd2, 5'd4,  "neg_sltu",   32'd0);
      issue(32'hFFFF_FFFF, 32'd2, 5'd7,  "neg_sra",    32'hFFFF_FFFF);
      issue(32'hFFFF_FFFF, 32'd2, 5'd6,  "neg_srl",    32'h3FFF_FFFF);
      issue(32'hFFFF_FFFF, 32'd2, 5'd11, "neg_mulh",   32'hFFFF_FFFF);
      issue(32'hFFFF_FFFF, 32'd2, 5'd13, "neg_mulhu",  32'h0000_0001);
      issue(32'hFFFF_FFFF, 32'd2, 5'd12, "neg_mulhsu", 32'hFFFF_FFFF);
      issue(32'hFFFF_FFFF, 32'd2, 5'd14, "neg_div",    32'd0);
      issue(32'hFFFF_FFFF, 32'd2, 5'd16, "neg_rem",    32'hFFFF_FFFF);

      issue(32'h1234, 32'd0, 5'd14, "div0_div",  32'hFFFF_FFFF);
      issue(32'h1234, 32'd0, 5'd15, "div0_divu", 32'hFFFF_FFFF);
      issue(32'h1234, 32'd0, 5'd16, "div0_rem",  32'h1234);
      issue(32'h1234, 32'd0, 5'd17, "div0_remu", 32'h1234);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "ovf_div", 32'h8000_0000);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 5'd16, "ovf_rem", 32'd0);

      issue(32'd1, 32'h21, 5'd2,  "sll_mask",  32'd2);
      issue(32'd6, 32'd3,  5'd18, "rsvd_18",   32'd0);
      issue(32'd6, 32'd3,  5'd31, "rsvd_31",   32'd0);

      for (int i = 0; i < 60; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = 5'($urandom_range(0, 19));
         if (i % 10 == 3) rb = 32'd0;
         if (i % 10 == 7) rb = 32'hFFFF_FFFF;
         issue(ra, rb, rop, $sformatf("rand%0d_op%0d", i, rop), ref_alu(ra, rb, rop));
      end

      // Leave a nonzero result in the register before the reset checks.
      issue(32'd6, 32'd3, 5'd0, "pre_reset_add", 32'd9);
      @(negedge clk);
      bus.DATA1  = 32'd7;
      bus.DATA2  = 32'd7;
      bus.OPCODE = 5'd0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("reset_async_clear", bus.ALU_OUTPUT, 32'd0);
      @(posedge clk);
      #1;
      check_eq("reset_hold", bus.ALU_OUTPUT, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_push(32'd1, 32'd1, 5'd0, "post_reset_add", 32'd2);

      repeat (3) @(negedge clk);
      check_eq("scoreboard_drain", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv32im_alu.md
# rv32im_alu

Registered 32-bit integer ALU for the RV32IM execute stage. It takes two operands and a 5-bit operation code and returns the result of any RV32I register-register arithmetic, logic, shift or compare operation, or any RV32M multiply/divide/remainder operation. The result is registered on the clock edge and handed to the EX/MEM pipeline register.

## Interface
- No parameters; data width is fixed at 32 bits.
- CLK  input  1  system clock, rising-edge active.
- RESET_N  input  1  asynchronous, active-low reset.
- DATA1  input  32  operand A (rs1 value).
- DATA2  input  32  operand B (rs2 value or immediate).
- OPCODE  input  5  operation select (codes below).
- ALU_OUTPUT  output  32  registered result.

## Operation
The ALU computes the result combinationally from the current DATA1, DATA2 and OPCODE. That result is captured into the ALU_OUTPUT register. Arithmetic wraps modulo 2^32 and raises no flags.

Opcode map:
- 0 ADD: A+B.
- 1 SUB: A−B.
- 2 SLL: A << B[4:0].
- 3 SLT: 1 if signed(A) < signed(B), else 0.
- 4 SLTU: 1 if unsigned(A) < unsigned(B), else 0.
- 5 XOR: A^B.
- 6 SRL: logical shift right of A by B[4:0].
- 7 SRA: arithmetic shift right of A by B[4:0] (sign fill).
- 8 OR: A|B.
- 9 AND: A&B.
- 10 MUL: low 32 bits of A×B.
- 11 MULH: high 32 bits of signed×signed 64-bit product.
- 12 MULHSU: high 32 bits of signed(A)×unsigned(B).
- 13 MULHU: high 32 bits of unsigned×unsigned.
- 14 DIV: signed quotient, truncated toward zero.
- 15 DIVU: unsigned quotient.
- 16 REM: signed remainder; its sign follows the dividend.
- 17 REMU: unsigned remainder.
- 18–31: reserved; result is 0x00000000.

Boundary rules, following the RISC-V spec; no traps:
- Shifts use only DATA2[4:0]; DATA2[31:5] is ignored.
- DIV by 0 → 0xFFFFFFFF. DIVU by 0 → 0xFFFFFFFF.
- REM by 0 → DATA1. REMU by 0 → DATA1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; the matching REM → 0.
- SLT and SLTU write 0 or 1 into bit 0; bits 31:1 are zero.

## Timing
- While RESET_N is low: ALU_OUTPUT = 0x00000000 immediately, with no dependence on CLK.
- After RESET_N deasserts, the first rising CLK edge loads a valid result.
- Latency is one cycle for every opcode, including multiply and divide. On each rising CLK edge ALU_OUTPUT takes f(DATA1, DATA2, OPCODE) as sampled just before that edge.
- The block uses no handshake or stall signals. A new operation may be issued every cycle, giving throughput of 1 per cycle.
- Inputs are held stable around the edge. ALU_OUTPUT changes only on a CLK edge or on reset assertion.
- If reset asserts mid-stream, the pending result is discarded. The output stays 0 until the first edge after release.

## Test plan
- Hold DATA1=6, DATA2=3 and sweep OPCODE 0..17, one per cycle. The output one cycle after each code must be:
  - codes 0–9: 9, 3, 48, 0, 0, 5, 0, 0, 7, 2;
  - codes 10–17: 18, 0, 0, 0, 2, 2, 0, 0.
- Signed/unsigned split with DATA1=0xFFFFFFFF (−1), DATA2=2:
  - SLT→1, SLTU→0, SRA→0xFFFFFFFF, SRL→0x3FFFFFFF;
  - MULH→0xFFFFFFFF, MULHU→0x00000001, MULHSU→0xFFFFFFFF;
  - DIV→0, REM→0xFFFFFFFF.
- Divide edge cases:
  - DATA1=0x1234, DATA2=0: DIV and DIVU→0xFFFFFFFF, REM and REMU→0x1234.
  - DATA1=0x80000000, DATA2=0xFFFFFFFF: DIV→0x80000000, REM→0.
- Shift masking: DATA1=1, DATA2=0x21 → SLL gives 2, since only DATA2[4:0] is used.
- Reserved opcodes 18 and 31 with DATA1=6, DATA2=3 → 0.
- Reset behaviour:
  - Drive RESET_N low between clock edges: ALU_OUTPUT clears to 0 without waiting for an edge.
  - After release, the first CLK edge with ADD 1+1 gives 2.
